usb_key_event_sched: RTL

//  Keyboard event scheduler between the USB HID key decoder and the Z80 bus.

---
 rtl/usb_key_event_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/usb_key_event_sched.sv
// rtl/usb_key_event_sched.sv - keyboard event FIFO with typematic repeat and register window
module usb_key_event_sched #(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned CNT_W         = 23,
  parameter int unsigned FIRST_DELAY   = 8000000,
  parameter int unsigned REPEAT_PERIOD = 1200000,
  parameter int unsigned REPEAT_LIMIT  = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       key_valid_i,
  input  logic [7:0] key_code_i,
  input  logic       key_held_i,
  input  logic       usb_cs,
  input  logic       wr_n,
  input  logic [7:0] reg_addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FIRST_LOAD  = CNT_W'(FIRST_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [AW:0]      DEPTH_CNT   = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rcode_q, rcode_d;
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             rpt_en_q, rpt_en_d;
  logic             cs_q;
  logic             irq_q, irq_d;
  logic [7:0]       mem_q [DEPTH];

  logic acc, rd_acc, wr_acc, empty, full;
  logic flush, ovf_clr, rpt_wr, pop;
  logic tick, tick_push, push_req, push, ovf_set;
  logic [7:0] push_data;
  logic unused_data_bits;

  // Bits of the write data that no register uses.
  assign unused_data_bits = ^data_i[7:2];

  // One register action per rising edge of the chip select.
  assign acc     = usb_cs & ~cs_q;
  assign rd_acc  = acc & wr_n;
  assign wr_acc  = acc & ~wr_n;
  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_CNT);
  assign flush   = wr_acc & (reg_addr_i == 8'h00) & data_i[0];
  assign ovf_clr = wr_acc & (reg_addr_i == 8'h00) & data_i[1];
  assign rpt_wr  = wr_acc & (reg_addr_i == 8'h03);
  assign pop     = rd_acc & (reg_addr_i == 8'h01) & ~empty;

  // Repeat timer FSM: flush or disable first, release next, new key restarts the delay.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rcode_d = rcode_q;
    tick    = 1'b0;
    if (flush || (rpt_wr && !data_i[0]) || !rpt_en_q) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (key_valid_i) begin
            state_d = S_DELAY;
            rcode_d = key_code_i;
            cnt_d   = FIRST_LOAD;
          end
        end
        S_DELAY, S_REPEAT: begin
          if (!key_held_i) begin
            state_d = S_IDLE;
          end else if (key_valid_i) begin
            state_d = S_DELAY;
            rcode_d = key_code_i;
            cnt_d   = FIRST_LOAD;
          end else if (cnt_q == '0) begin
            state_d = S_REPEAT;
            tick    = 1'b1;
            cnt_d   = PERIOD_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Push arbitration and FIFO bookkeeping; a key press always beats a repeat tick.
  always_comb begin
    tick_push = tick & (32'(count_q) < REPEAT_LIMIT);
    push_req  = key_valid_i | tick_push;
    push_data = key_valid_i ? key_code_i : rcode_q;
    push      = push_req & ~flush & (~full | pop);
    ovf_set   = push_req & ~flush & full & ~pop;
    wp_d      = wp_q;
    rp_d      = rp_q;
    count_d   = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      wp_d    = wp_q + AW'(push);
      rp_d    = rp_q + AW'(pop);
      count_d = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end
    ovf_d    = (ovf_q & ~ovf_clr) | ovf_set;
    rpt_en_d = rpt_wr ? data_i[0] : rpt_en_q;
    irq_d    = ~empty;
  end

  // Register read mux, decoded from the address alone.
  always_comb begin
    data_o = 8'h00;
    case (reg_addr_i)
      8'h00:   data_o = {5'b0, ovf_q, full, ~empty};
      8'h01:   data_o = empty ? 8'h00 : mem_q[rp_q];
      8'h02:   data_o = 8'(count_q);
      8'h03:   data_o = {7'b0, rpt_en_q};
      default: data_o = 8'h00;
    endcase
  end

  // FIFO storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wp_q] <= push_data;
  end

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rcode_q  <= 8'h00;
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rpt_en_q <= 1'b1;
      cs_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rcode_q  <= rcode_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rpt_en_q <= rpt_en_d;
      cs_q     <= usb_cs;
      irq_q    <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule
